hybrid_tdc: RTL and testbench

Hybrid time-to-digital converter: the receive-side counterpart of the hybrid DPWM. It measures the high time of a PWM waveform and returns the same 9-bit duty code the DPWM consumes: a 6-bit coarse clock count plus a 3-bit fine fraction interpolated from an 8-tap delay line. It sits on the feedback path between the power stage's gate-drive sense and the compensator, for closed-loop duty verification and calibration.

---
 rtl/hybrid_tdc_pkg.sv | 18 +
 rtl/hybrid_tdc_if.sv | 22 ++
 rtl/hybrid_tdc_therm_popcount.sv | 23 ++
 rtl/hybrid_tdc.sv | 220 ++++++++++++++++++++++
 tb/tb_hybrid_tdc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/hybrid_tdc_pkg.sv
// tdc_pkg: shared widths, constants and FSM encoding for the hybrid TDC.
package tdc_pkg;

    localparam int COARSE_W = 6;
    localparam int FINE_W   = 3;
    localparam int CODE_W   = 9;

    localparam logic [CODE_W-1:0] CODE_OVF  = 9'h1FF;
    localparam logic [CODE_W-1:0] CODE_ZERO = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_DONE      = 2'd3
    } tdc_state_e;

endpackage

// File: rtl/hybrid_tdc_if.sv
// hybrid_tdc_if: PWM tap inputs, frame sync and measured duty-code outputs.
interface hybrid_tdc_if;
    import tdc_pkg::*;

    logic              en;
    logic              frame_sync;
    logic [7:0]        pwm_taps;
    logic [CODE_W-1:0] duty_code;
    logic              code_valid;
    logic              no_pulse;
    logic              overflow;

    modport master (
        output en, frame_sync, pwm_taps,
        input  duty_code, code_valid, no_pulse, overflow
    );

    modport slave (
        input  en, frame_sync, pwm_taps,
        output duty_code, code_valid, no_pulse, overflow
    );
endinterface

// File: rtl/hybrid_tdc_therm_popcount.sv
// therm_popcount: counts set taps of a 7-bit thermometer code, clamped to 3 bits.
// Counting ones rather than locating the first zero makes isolated bubbles harmless.
module therm_popcount
    import tdc_pkg::*;
(
    input  logic [6:0]        therm,
    output logic [FINE_W-1:0] fine
);
    logic [3:0] sum_s;

    // Sum the set taps and saturate at the largest fine code
    always_comb begin
        sum_s = 4'd0;
        for (int i = 0; i < 7; i++) begin
            sum_s = sum_s + {3'd0, therm[i]};
        end
        if (sum_s > 4'd7) begin
            fine = 3'd7;
        end else begin
            fine = sum_s[2:0];
        end
    end
endmodule

// File: rtl/hybrid_tdc.sv
// hybrid_tdc: measures the high time of a PWM frame as {coarse[5:0], fine[2:0]}.
// Optional macro HYBRID_TDC_AVG4_EN: report the rounded mean of the last four
// good captures instead of the single-frame capture.
module hybrid_tdc
    import tdc_pkg::*;
#(
    parameter int FRAME_LEN = 64
)(
    input  logic        clk,
    input  logic        rst_n,
    hybrid_tdc_if.slave bus
);
    localparam logic [COARSE_W-1:0] CNT_LAST = COARSE_W'(FRAME_LEN - 1);

    logic [7:0]          taps_s1_r, taps_s2_r;
    logic                fs_d1_r;
    logic [COARSE_W-1:0] cnt_r, prev_cnt_r;
    tdc_state_e          state_r, state_s;
    logic [CODE_W-1:0]   capture_r, pub_code_s, duty_code_r;
    logic [FINE_W-1:0]   fine_s;
    logic                high_s, frame_end_s, fall_s, pub_s, pub_np_s, pub_ovf_s;
    logic                code_valid_r, no_pulse_r, overflow_r;

    assign high_s      = taps_s2_r[0];
    assign frame_end_s = (cnt_r == CNT_LAST);

    therm_popcount u_popcount (
        .therm (taps_s2_r[7:1]),
        .fine  (fine_s)
    );

    // Two-stage tap synchronizer plus the first frame_sync delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_s1_r <= 8'd0;
            taps_s2_r <= 8'd0;
            fs_d1_r   <= 1'b0;
        end else begin
            taps_s1_r <= bus.pwm_taps;
            taps_s2_r <= taps_s1_r;
            fs_d1_r   <= bus.frame_sync;
        end
    end

    // Frame counter; loading from the first sync stage acts as the second delay,
    // so the counter reads 0 exactly when s2 holds the count-0 taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 6'd0;
        end else if (fs_d1_r) begin
            cnt_r <= 6'd0;
        end else begin
            cnt_r <= cnt_r + 6'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and the result to publish at the last count of the frame
    always_comb begin
        state_s    = state_r;
        fall_s     = 1'b0;
        pub_s      = 1'b0;
        pub_code_s = CODE_ZERO;
        pub_np_s   = 1'b0;
        pub_ovf_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fs_d1_r && bus.en) begin
                    state_s = ST_WAIT_HIGH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (frame_end_s) begin
                    pub_s = 1'b1;
                    if (high_s) begin
                        pub_code_s = CODE_OVF;
                        pub_ovf_s  = 1'b1;
                    end else begin
                        pub_code_s = CODE_ZERO;
                        pub_np_s   = 1'b1;
                    end
                end else if (high_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_WAIT_HIGH;
                end
            end
            ST_HIGH: begin
                if (frame_end_s) begin
                    pub_s = 1'b1;
                    if (high_s) begin
                        pub_code_s = CODE_OVF;
                        pub_ovf_s  = 1'b1;
                    end else begin
                        pub_code_s = {prev_cnt_r, fine_s};
                    end
                end else if (!high_s) begin
                    fall_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_DONE: begin
                if (frame_end_s) begin
                    pub_s      = 1'b1;
                    pub_code_s = capture_r;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Frame boundary and mid-frame resync override the per-state choice
        if (pub_s) begin
            state_s = bus.en ? ST_WAIT_HIGH : ST_IDLE;
        end else if (fs_d1_r && (state_r != ST_IDLE)) begin
            state_s = ST_WAIT_HIGH;
        end else begin
            state_s = state_s;
        end
    end

    // Track the last high count and latch the code at the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt_r <= 6'd0;
            capture_r  <= CODE_ZERO;
        end else begin
            if (((state_r == ST_WAIT_HIGH) || (state_r == ST_HIGH)) && high_s) begin
                prev_cnt_r <= cnt_r;
            end
            if (fall_s) begin
                capture_r <= {prev_cnt_r, fine_s};
            end
        end
    end

`ifdef HYBRID_TDC_AVG4_EN
    logic [2:0][CODE_W-1:0] hist_r;
    logic [2:0]             good_cnt_r;
    logic                   good_s;
    logic [10:0]            sum_s;

    assign good_s = pub_s & ~pub_np_s & ~pub_ovf_s;
    assign sum_s  = {2'b00, pub_code_s} + {2'b00, hist_r[0]} + {2'b00, hist_r[1]}
                  + {2'b00, hist_r[2]} + 11'd2;

    // History of the three previous good captures and a saturating good count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r     <= {(3*CODE_W){1'b0}};
            good_cnt_r <= 3'd0;
        end else if (good_s) begin
            hist_r <= {hist_r[1:0], pub_code_s};
            if (good_cnt_r != 3'd4) begin
                good_cnt_r <= good_cnt_r + 3'd1;
            end
        end
    end

    // Registered outputs: averaged code once four good captures exist
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_code_r  <= CODE_ZERO;
            code_valid_r <= 1'b0;
            no_pulse_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (good_s) begin
            code_valid_r <= (good_cnt_r >= 3'd3);
            if (good_cnt_r >= 3'd3) begin
                duty_code_r <= CODE_W'(sum_s >> 2);
                no_pulse_r  <= 1'b0;
                overflow_r  <= 1'b0;
            end
        end else if (pub_s && (good_cnt_r == 3'd4)) begin
            code_valid_r <= 1'b1;
            no_pulse_r   <= pub_np_s;
            overflow_r   <= pub_ovf_s;
        end else begin
            code_valid_r <= 1'b0;
        end
    end
`else
    // Registered outputs: single-frame capture published at the frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_code_r  <= CODE_ZERO;
            code_valid_r <= 1'b0;
            no_pulse_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            code_valid_r <= pub_s;
            if (pub_s) begin
                duty_code_r <= pub_code_s;
                no_pulse_r  <= pub_np_s;
                overflow_r  <= pub_ovf_s;
            end
        end
    end
`endif

    assign bus.duty_code  = duty_code_r;
    assign bus.code_valid = code_valid_r;
    assign bus.no_pulse   = no_pulse_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_hybrid_tdc.sv
// tb_hybrid_tdc: directed self-checking bench for hybrid_tdc.
`timescale 1ns/1ps
module tb_hybrid_tdc;
    import tdc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    hybrid_tdc_if hif();

    hybrid_tdc #(.FRAME_LEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int cv_cnt = 0;
    int cv_edge = 0;
    int cv_prev_edge = 0;
    int last_sync_edge = 0;
    logic [8:0] cv_code = 9'd0;
    logic cv_np = 1'b0;
    logic cv_ovf = 1'b0;

    // Count rising edges so latencies can be measured in clocks
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Capture every code_valid pulse on the falling edge
    always @(negedge clk) begin
        if (hif.code_valid === 1'b1) begin
            cv_cnt       <= cv_cnt + 1;
            cv_prev_edge <= cv_edge;
            cv_edge      <= edge_cnt;
            cv_code      <= hif.duty_code;
            cv_np        <= hif.no_pulse;
            cv_ovf       <= hif.overflow;
        end
    end

    // Ideal DPWM tap k is high at count n when 8n - k <= d
    function automatic logic [7:0] dpwm_taps(input int n, input int d);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = ((8 * n - k) <= d);
        return t;
    endfunction

    // mode 0 ideal DPWM, 1 all low, 2 all high, 3 bubbled fall at count 11
    task automatic drive_frame(input int mode, input int d, input int ncyc, input int en_drop);
        for (int n = 0; n < ncyc; n++) begin
            hif.frame_sync = (n == 0);
            if (n == 0) last_sync_edge = edge_cnt + 1;
            case (mode)
                0: hif.pwm_taps = dpwm_taps(n, d);
                1: hif.pwm_taps = 8'h00;
                2: hif.pwm_taps = 8'hFF;
                3: hif.pwm_taps = (n <= 10) ? 8'hFF : ((n == 11) ? 8'b1101_1000 : 8'h00);
                default: hif.pwm_taps = 8'h00;
            endcase
            if (n == en_drop) hif.en = 1'b0;
            @(posedge clk); #1;
        end
        hif.frame_sync = 1'b0;
    endtask

    task automatic tail(input int ncyc);
        hif.pwm_taps = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hif.duty_code !== 9'd0) begin failures++; $display("FAIL reset_code got=%0d want=0", hif.duty_code); end
        checks++; if (hif.code_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", hif.code_valid); end
        checks++; if (hif.no_pulse !== 1'b0) begin failures++; $display("FAIL reset_no_pulse got=%b want=0", hif.no_pulse); end
        checks++; if (hif.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", hif.overflow); end
        rst_n = 1'b1;
        tail(2);
    endtask

    task automatic test_nominal();
        int c0 = cv_cnt;
        drive_frame(0, 200, 64, -1);
        drive_frame(0, 200, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 2) begin failures++; $display("FAIL nominal_count got=%0d want=2", cv_cnt - c0); end
        checks++; if (cv_code !== 9'd200) begin failures++; $display("FAIL nominal_code got=%0d want=200", cv_code); end
        checks++; if ({cv_np, cv_ovf} !== 2'b00) begin failures++; $display("FAIL nominal_flags got=%b want=00", {cv_np, cv_ovf}); end
        checks++; if (cv_edge - cv_prev_edge != 64) begin failures++; $display("FAIL nominal_period got=%0d want=64", cv_edge - cv_prev_edge); end
    endtask

    task automatic test_single(input string name, input int mode, input int d,
                               input logic [8:0] exp_code, input logic exp_np, input logic exp_ovf);
        int c0 = cv_cnt;
        drive_frame(mode, d, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 1) begin failures++; $display("FAIL %s_count got=%0d want=1", name, cv_cnt - c0); end
        checks++; if (cv_code !== exp_code) begin failures++; $display("FAIL %s_code got=%0d want=%0d", name, cv_code, exp_code); end
        checks++; if ({cv_np, cv_ovf} !== {exp_np, exp_ovf}) begin failures++; $display("FAIL %s_flags got=%b want=%b", name, {cv_np, cv_ovf}, {exp_np, exp_ovf}); end
    endtask

    task automatic test_midframe_sync();
        int c0 = cv_cnt;
        drive_frame(0, 200, 30, -1);
        drive_frame(0, 205, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 1) begin failures++; $display("FAIL resync_count got=%0d want=1", cv_cnt - c0); end
        checks++; if (cv_code !== 9'd205) begin failures++; $display("FAIL resync_code got=%0d want=205", cv_code); end
    endtask

    task automatic test_en_low();
        int c0 = cv_cnt;
        drive_frame(0, 200, 64, 30);
        tail(3);
        checks++; if (cv_cnt - c0 != 1) begin failures++; $display("FAIL en_drop_count got=%0d want=1", cv_cnt - c0); end
        checks++; if (cv_code !== 9'd200) begin failures++; $display("FAIL en_drop_code got=%0d want=200", cv_code); end
        c0 = cv_cnt;
        drive_frame(0, 205, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 0) begin failures++; $display("FAIL en_idle_count got=%0d want=0", cv_cnt - c0); end
        hif.en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int c0;
        drive_frame(0, 200, 31, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (hif.duty_code !== 9'd0) begin failures++; $display("FAIL midreset_code got=%0d want=0", hif.duty_code); end
        checks++; if (hif.code_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b want=0", hif.code_valid); end
        rst_n = 1'b1;
        c0 = cv_cnt;
        tail(80);
        checks++; if (cv_cnt - c0 != 0) begin failures++; $display("FAIL nosync_count got=%0d want=0", cv_cnt - c0); end
        drive_frame(0, 205, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 1) begin failures++; $display("FAIL postreset_count got=%0d want=1", cv_cnt - c0); end
        checks++; if (cv_code !== 9'd205) begin failures++; $display("FAIL postreset_code got=%0d want=205", cv_code); end
        checks++; if (cv_edge - last_sync_edge + 1 != 66) begin failures++; $display("FAIL latency got=%0d want=66", cv_edge - last_sync_edge + 1); end
    endtask

    task automatic test_avg4();
        int c0 = cv_cnt;
        drive_frame(0, 100, 64, -1);
        drive_frame(0, 101, 64, -1);
        drive_frame(0, 102, 64, -1);
        drive_frame(0, 104, 64, -1);
        tail(3);
        checks++; if (cv_cnt - c0 != 1) begin failures++; $display("FAIL avg_count got=%0d want=1", cv_cnt - c0); end
        checks++; if (cv_code !== 9'd102) begin failures++; $display("FAIL avg_code got=%0d want=102", cv_code); end
    endtask

    initial begin
        rst_n          = 1'b0;
        hif.en         = 1'b1;
        hif.frame_sync = 1'b0;
        hif.pwm_taps   = 8'h00;
        test_reset();
`ifdef HYBRID_TDC_AVG4_EN
        test_avg4();
`else
        test_nominal();
        test_single("fine", 0, 205, 9'd205, 1'b0, 1'b0);
        test_single("no_pulse", 1, 0, 9'd0, 1'b1, 1'b0);
        test_single("overflow", 2, 0, 9'h1FF, 1'b0, 1'b1);
        test_single("bubble", 3, 0, 9'd84, 1'b0, 1'b0);
        test_midframe_sync();
        test_en_low();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
